// File: rtl/bus_timer_pkg.sv
// Shared constants for the bus_timer peripheral: register offsets, bit
// positions within STATUS/CONTROL, and the address-decode nibble.
package bus_timer_pkg;

  localparam logic [2:0] OFF_STATUS  = 3'd0;
  localparam logic [2:0] OFF_CONTROL = 3'd1;
  localparam logic [2:0] OFF_PERIOD  = 3'd2;
  localparam logic [2:0] OFF_COUNT   = 3'd3;

  // STATUS bits
  localparam int BIT_TO    = 0;
  localparam int BIT_RUN   = 1;
  // CONTROL bits
  localparam int BIT_START = 0;
  localparam int BIT_STOP  = 1;
  localparam int BIT_CONT  = 2;
  localparam int BIT_IE    = 3;

  localparam logic [3:0] BASE_NIBBLE = 4'h4;

endpackage

// File: rtl/bus_timer_tick_gen.sv
// Prescaler: free-runs 0..PRESCALE-1 while enabled and pulses tick on the
// last count; held at zero when disabled or cleared.
module tick_gen #(
  parameter int PRESCALE = 50000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);
  assign tick   = enable & w_last;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)                          r_cnt <= '0;
    else if (clear || !enable || w_last) r_cnt <= '0;
    else                                r_cnt <= r_cnt + CW'(1);
  end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped interval timer: counts prescaled ticks down from PERIOD,
// sets a sticky TO flag on expiry, optional reload and interrupt level.
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter int          PRESCALE   = 50000,
  parameter logic [15:0] PERIOD_RST = 16'hFFFF
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        cs,
  input  logic [2:0]  ADDR,
  input  logic [15:0] DOUT,
  input  logic        W,
  output logic [15:0] q,
  output logic        irq
);

  logic [15:0] r_period, r_count, r_q;
  logic        r_run, r_cont, r_ie, r_to;

  logic        w_wr, w_wr_status, w_wr_ctrl, w_wr_period;
  logic        w_start, w_stop, w_per_zero, w_expire, w_tick;
  logic [15:0] w_rd_data;

  assign w_wr        = cs & W;
  assign w_wr_status = w_wr & (ADDR == OFF_STATUS);
  assign w_wr_ctrl   = w_wr & (ADDR == OFF_CONTROL);
  assign w_wr_period = w_wr & (ADDR == OFF_PERIOD);

  // STOP dominates START when both arrive in one write
  assign w_stop     = w_wr_ctrl & DOUT[BIT_STOP];
  assign w_start    = w_wr_ctrl & DOUT[BIT_START] & ~DOUT[BIT_STOP];
  assign w_per_zero = (r_period == 16'd0);
  assign w_expire   = w_tick & (r_count == 16'd1) & ~w_stop & ~w_start;

  tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .Clock  (Clock),
    .Reset  (Reset),
    .clear  (w_start | w_stop),
    .enable (r_run),
    .tick   (w_tick)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_period <= PERIOD_RST;
      r_count  <= '0;
      r_run    <= 1'b0;
      r_cont   <= 1'b0;
      r_ie     <= 1'b0;
      r_to     <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_cont <= DOUT[BIT_CONT];
        r_ie   <= DOUT[BIT_IE];
      end
      if (w_wr_period) r_period <= DOUT;

      if (w_stop) begin
        r_run <= 1'b0;
      end else if (w_start) begin
        if (w_per_zero) begin
          r_run <= 1'b0;
        end else begin
          r_count <= r_period;
          r_run   <= 1'b1;
        end
      end else if (w_tick) begin
        if (r_count > 16'd1) begin
          r_count <= r_count - 16'd1;
        end else if (r_cont && !w_per_zero) begin
          r_count <= r_period;
        end else begin
          // one-shot end, or a reload of zero would never expire again
          r_count <= '0;
          r_run   <= 1'b0;
        end
      end

      if (w_expire || (w_start && w_per_zero)) r_to <= 1'b1;
      else if (w_wr_status)                     r_to <= 1'b0;
    end
  end

  always_comb begin
    w_rd_data = '0;
    case (ADDR)
      OFF_STATUS: begin
        w_rd_data[BIT_TO]  = r_to;
        w_rd_data[BIT_RUN] = r_run;
      end
      OFF_CONTROL: begin
        w_rd_data[BIT_CONT] = r_cont;
        w_rd_data[BIT_IE]   = r_ie;
      end
      OFF_PERIOD: w_rd_data = r_period;
      OFF_COUNT:  w_rd_data = r_count;
      default:    w_rd_data = '0;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) r_q <= '0;
    else       r_q <= cs ? w_rd_data : 16'd0;
  end

  assign q   = r_q;
  assign irq = r_to & r_ie;

endmodule

// File: doc/bus_timer.md
Name: bus_timer

Overview:
- Memory-mapped interval-timer peripheral.
- Sits on the processor's ADDR/DOUT/W/DIN bus as a responder. The top level decodes ADDR[15:12]==4'h4 into cs and muxes q onto DIN.
- Counts prescaled clock ticks down from a programmable period. It raises a sticky timeout flag and an optional interrupt level.
- The processor polls the timer through synchronous register reads, with the same 1-cycle latency as inst_mem.

Parameters:
- PRESCALE, 50000, clock cycles per timer tick (>=1); 50000 gives a 1 ms tick at 50 MHz.
- PERIOD_RST, 16'hFFFF, reset value of the PERIOD register.

Ports:
- Clock  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- cs     input  1  chip select, decoded from ADDR[15:12]==4'h4.
- ADDR   input  3  register offset, ADDR[2:0].
- DOUT   input  16  write data from the processor.
- W      input  1  write strobe; a write occurs when cs & W.
- q      output 16  registered read data, valid 1 cycle after cs.
- irq    output 1  interrupt level, equal to TO & IE.

Behaviour:
- Register map (offset):
  - 0 STATUS: bit0 TO, bit1 RUN; any write clears TO.
  - 1 CONTROL (write): bit0 START, bit1 STOP, bit2 CONT, bit3 IE. CONT and IE are stored; START and STOP are one-shot. Read returns {12'b0, IE, CONT, 2'b0}.
  - 2 PERIOD (R/W), 16 bits.
  - 3 COUNT (read-only); writes ignored.
  - 4-7: read 16'h0; writes ignored.
- Reset: PERIOD=PERIOD_RST, COUNT=0, prescaler=0, RUN=0, CONT=0, IE=0, TO=0, q=0, irq=0.
- Read latency:
  - q <= selected register on every edge where cs=1.
  - q <= 0 when cs=0.
  - The value returned is the register value before that edge's update.
- Prescaler:
  - Counts 0..PRESCALE-1 while RUN=1; tick=1 when it equals PRESCALE-1, then it wraps to 0.
  - Held at 0 while RUN=0.
  - PRESCALE=1 gives a tick every cycle.
- START with PERIOD!=0:
  - COUNT<=PERIOD, prescaler<=0, RUN<=1.
  - Takes effect the cycle after the write.
- START with PERIOD==0: RUN stays 0, TO<=1 on that edge.
- START while running restarts (reload + prescaler clear).
- STOP: RUN<=0; COUNT is frozen at its current value. STOP and START in the same write: STOP wins.
- Tick while RUN:
  - COUNT>1: COUNT<=COUNT-1.
  - COUNT==1: TO<=1. If CONT, COUNT<=PERIOD and RUN stays 1; else COUNT<=0 and RUN<=0.
  - The first timeout therefore occurs PERIOD*PRESCALE cycles after the START write edge.
- A PERIOD write while running does not affect the current COUNT; it is used at the next reload.
- TO is sticky. Timeout and a STATUS-clear write on the same edge: set wins, TO=1.
- A CONTROL write carrying only CONT/IE changes (START=STOP=0) does not disturb COUNT or RUN.
- irq is combinational from the TO and IE flops (glitch-free).
- Reset asserted mid-count returns all state to reset values immediately; counting resumes only on a new START.
- COUNT never wraps below 0.

Decomposition:
- Shared package bus_timer_pkg holds:
  - offset constants OFF_STATUS=0, OFF_CONTROL=1, OFF_PERIOD=2, OFF_COUNT=3;
  - bit positions for TO, RUN, START, STOP, CONT, IE;
  - the peripheral base nibble 4'h4, for the top-level decode.
- One sub-module, tick_gen: the parameterised prescaler. Inputs Clock, Reset, clear, enable; output tick.

Test Plan (PRESCALE=4 in bench):
- Reset, then read offsets 0,1,2,3 -> q = 0, 0, 16'hFFFF, 0, each one cycle after its cs cycle.
- Write PERIOD=3, CONTROL=1 -> RUN=1, COUNT reads 3,2,1 at 4-cycle spacing. TO=1 exactly 12 cycles after the START edge, then RUN=0 and COUNT=0; irq stays 0 (IE=0).
- PERIOD=2, CONTROL=4'b1101 (CONT, IE, START) -> TO/irq rise after 8 cycles, COUNT reloads to 2, RUN stays 1. Write STATUS -> TO/irq clear. Timeout recurs 8 cycles after the previous one.
- Continuous run with a STATUS write on the same edge as a timeout -> TO remains 1.
- CONTROL=4'b0011 (START+STOP) while running -> RUN=0, COUNT frozen.
- PERIOD=0, START -> TO=1 next cycle, RUN=0.
- Reset pulse mid-count (COUNT=5) -> next read shows COUNT=0, STATUS=0; no further timeout.
